machine_timer: RTL and testbench

MACHINE_TIMER -- requirements
Module: machine_timer

---
 rtl/machine_timer.sv | 162 ++++++++++++++++
 tb/tb_machine_timer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped 64-bit machine timer with compare interrupt.
//
// Ports
//   clk             : single clock, all state on the rising edge
//   rst             : asynchronous, active-low reset
//   req             : bus access request, held high until ready
//   we              : 1 = write, 0 = read (valid while req is high)
//   addr[4:0]       : word-aligned byte address
//   wdata[31:0]     : write data
//   rdata[31:0]     : registered read data, valid while ready is high
//   ready           : one-cycle access-complete pulse
//   timer_interrupt : registered level interrupt, IRQ_EN && (mtime >= mtimecmp)
//
// Register map (addr[4:2])
//   0x00 MTIME_LO     RW  (reading it snapshots mtime[63:32])
//   0x04 MTIME_HI     RW  (reads return the snapshot)
//   0x08 MTIMECMP_LO  RW
//   0x0C MTIMECMP_HI  RW
//   0x10 CTRL         RW  bit0 CNT_EN, bit1 IRQ_EN
//   0x14 STATUS       RO  bit0 = (mtime >= mtimecmp)
//   others: read 0, writes ignored, still acknowledged
module machine_timer #(
  parameter int unsigned PRESCALE  = 4,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        timer_interrupt
);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;

  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [7:0]  presc_q, presc_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        irq_q, irq_d;

  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic        cmp_ge;
  logic [2:0]  idx;
  logic [31:0] rd_mux;

  // Handshake: the requester holds req until it sees ready. A request is
  // accepted on an edge where req is high and ready_q is low; that edge
  // raises ready for one cycle, commits a write and registers read data.
  // Because ready_q blocks acceptance on the following edge, a continuously
  // held req completes one access every two cycles.
  always_comb begin
    idx    = addr[4:2];
    access = req && !ready_q;
    wr_en  = access && we;
    rd_en  = access && !we;
    cmp_ge = (mtime_q >= mtimecmp_q);
    tick   = ctrl_q[0] && (presc_q == PRESC_MAX);

    presc_d    = presc_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    snap_d     = snap_q;
    rdata_d    = rdata_q;
    ready_d    = access;
    irq_d      = ctrl_q[1] && cmp_ge;

    if (ctrl_q[0]) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
    end
    // Full 64-bit add so the low-to-high carry lands on the same edge.
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    // Bus writes are applied after the tick so a write to mtime wins.
    if (wr_en) begin
      case (idx)
        A_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], wdata};
          presc_d = 8'd0;
        end
        A_MTIME_HI: begin
          mtime_d = {wdata, mtime_q[31:0]};
          presc_d = 8'd0;
        end
        A_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wdata};
        A_CMP_HI: mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        A_CTRL: begin
          ctrl_d = wdata[1:0];
          if (!wdata[0]) begin
            presc_d = 8'd0;
          end
        end
        default: ;
      endcase
    end

    rd_mux = 32'd0;
    case (idx)
      A_MTIME_LO: rd_mux = mtime_q[31:0];
      A_MTIME_HI: rd_mux = snap_q;
      A_CMP_LO:   rd_mux = mtimecmp_q[31:0];
      A_CMP_HI:   rd_mux = mtimecmp_q[63:32];
      A_CTRL:     rd_mux = {30'd0, ctrl_q};
      A_STATUS:   rd_mux = {31'd0, cmp_ge};
      default:    rd_mux = 32'd0;
    endcase

    if (rd_en) begin
      rdata_d = rd_mux;
      // Low and high halves then come from the same pre-edge mtime value.
      if (idx == A_MTIME_LO) begin
        snap_d = mtime_q[63:32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= CMP_RESET;
      presc_q    <= 8'd0;
      ctrl_q     <= 2'd0;
      snap_q     <= 32'd0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      ctrl_q     <= ctrl_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata           = rdata_q;
  assign ready           = ready_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer. Instance 0 uses PRESCALE=4, instance 1
// uses PRESCALE=1; both share clock and reset.
module tb_machine_timer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        req_s   [2];
  logic        we_s    [2];
  logic [4:0]  addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        rdy_s   [2];
  logic        irq_s   [2];

  machine_timer #(.PRESCALE(4)) u_dut0 (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(rdy_s[0]),
    .timer_interrupt(irq_s[0])
  );

  machine_timer #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(rdy_s[1]),
    .timer_interrupt(irq_s[1])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus(input int s, input logic w, input logic [4:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output int at);
    bit got;
    req_s[s] = 1'b1; we_s[s] = w; addr_s[s] = a; wdata_s[s] = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (rdy_s[s]) got = 1'b1;
    end
    rd = rdata_s[s];
    at = cyc;
    req_s[s] = 1'b0;
    if (!got) check("bus_timeout", 64'd0, 64'd1);
  endtask

  task automatic wr(input int s, input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    int t;
    bus(s, 1'b1, a, d, dummy, t);
  endtask

  task automatic rd(input int s, input logic [4:0] a, output logic [31:0] v);
    int t;
    bus(s, 1'b0, a, 32'd0, v, t);
  endtask

  task automatic rd_chk(input string tag, input int s, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(s, a, v);
    check(tag, {32'd0, v}, {32'd0, exp});
  endtask

  // ---------------- tick spacing monitor (instance 0) ----------------
  bit          mon_en   = 1'b0;
  int          mon_last = 0;
  logic [63:0] mon_prev = 64'd0;

  always begin
    @(posedge clk); #1;
    if (mon_en && (u_dut0.mtime_q != mon_prev)) begin
      check("tick_spacing", 64'(cyc - mon_last), 64'd4);
      check("tick_step", u_dut0.mtime_q - mon_prev, 64'd1);
      mon_last = cyc;
      mon_prev = u_dut0.mtime_q;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    bit seen;
    bit found;
    int t1, t2;

    for (int s = 0; s < 2; s++) begin
      req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = 5'd0; wdata_s[s] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    // Reset in the middle of an access: request dropped, no ready.
    @(posedge clk); #1;
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 5'h10; wdata_s[0] = 32'd3;
    #2 rst = 1'b0;
    #1 check("rdata_in_reset", {32'd0, rdata_s[0]}, 64'd0);
    check("irq_in_reset", {63'd0, irq_s[0]}, 64'd0);
    seen = 1'b0;
    @(posedge clk); #1;
    seen |= rdy_s[0];
    req_s[0] = 1'b0;
    #2 rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= rdy_s[0];
    end
    check("abort_no_ready", {63'd0, seen}, 64'd0);

    // Reset values (HI read first: snapshot must be 0 from reset).
    rd_chk("rst_mtime_hi", 0, 5'h04, 32'd0);
    rd_chk("rst_mtime_lo", 0, 5'h00, 32'd0);
    rd_chk("rst_cmp_lo",   0, 5'h08, 32'hFFFF_FFFF);
    rd_chk("rst_cmp_hi",   0, 5'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl",     0, 5'h10, 32'd0);
    rd_chk("rst_status",   0, 5'h14, 32'd0);
    check("rst_irq", {63'd0, irq_s[0]}, 64'd0);
    repeat (10) @(posedge clk);
    rd_chk("no_count_before_en", 0, 5'h00, 32'd0);

    // Prescaled count with PRESCALE=4.
    wr(0, 5'h10, 32'd1);
    mon_prev = 64'd0;
    mon_last = cyc;
    mon_en   = 1'b1;
    repeat (40) @(posedge clk);
    rd(0, 5'h00, v);
    mon_en = 1'b0;
    check("count_40_cycles", {63'd0, (v >= 32'd9 && v <= 32'd11)}, 64'd1);

    // Interrupt assert at mtime == 20, then clear by raising mtimecmp.
    wr(0, 5'h10, 32'd0);
    wr(0, 5'h00, 32'd0);
    wr(0, 5'h04, 32'd0);
    wr(0, 5'h0C, 32'd0);
    wr(0, 5'h08, 32'd20);
    wr(0, 5'h10, 32'd3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (u_dut0.mtime_q == 64'd20) found = 1'b1;
    end
    check("reach_20", {63'd0, found}, 64'd1);
    check("irq_at_20", {63'd0, irq_s[0]}, 64'd0);
    @(posedge clk); #1;
    check("irq_rise", {63'd0, irq_s[0]}, 64'd1);
    rd_chk("status_set", 0, 5'h14, 32'd1);
    wr(0, 5'h08, 32'd100);
    check("irq_at_cmp_write", {63'd0, irq_s[0]}, 64'd1);
    @(posedge clk); #1;
    check("irq_fall_cmp", {63'd0, irq_s[0]}, 64'd0);
    rd_chk("status_clear", 0, 5'h14, 32'd0);

    // Clearing IRQ_EN also drops the interrupt one cycle later.
    wr(0, 5'h08, 32'd0);
    @(posedge clk); #1;
    check("irq_rise_cmp0", {63'd0, irq_s[0]}, 64'd1);
    wr(0, 5'h10, 32'd1);
    check("irq_at_en_write", {63'd0, irq_s[0]}, 64'd1);
    @(posedge clk); #1;
    check("irq_fall_en", {63'd0, irq_s[0]}, 64'd0);

    // Bus corner cases: writes to STATUS and unmapped space do nothing.
    wr(0, 5'h14, 32'hFFFF_FFFF);
    wr(0, 5'h18, 32'hFFFF_FFFF);
    rd_chk("ctrl_kept",   0, 5'h10, 32'd1);
    rd_chk("cmp_lo_kept", 0, 5'h08, 32'd0);
    rd_chk("cmp_hi_kept", 0, 5'h0C, 32'd0);
    rd_chk("status_ro",   0, 5'h14, 32'd1);
    rd_chk("unmapped_18", 0, 5'h18, 32'd0);
    rd_chk("unmapped_1c", 0, 5'h1C, 32'd0);
    bus(0, 1'b0, 5'h10, 32'd0, v, t1);
    bus(0, 1'b0, 5'h10, 32'd0, v, t2);
    check("b2b_spacing", 64'(t2 - t1), 64'd2);
    check("b2b_data", {32'd0, v}, 64'd1);

    // Wrap with PRESCALE=1.
    wr(1, 5'h00, 32'hFFFF_FFFF);
    wr(1, 5'h04, 32'hFFFF_FFFF);
    wr(1, 5'h10, 32'd1);
    check("wrap_pre", u_dut1.mtime_q, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    check("wrap_zero", u_dut1.mtime_q, 64'd0);
    @(posedge clk); #1;
    check("every_cycle", u_dut1.mtime_q, 64'd1);

    // Atomic read across the low-to-high carry.
    wr(1, 5'h10, 32'd0);
    wr(1, 5'h00, 32'hFFFF_FFFE);
    wr(1, 5'h04, 32'd0);
    wr(1, 5'h10, 32'd1);
    rd_chk("atomic_lo", 1, 5'h00, 32'hFFFF_FFFF);
    rd_chk("atomic_hi", 1, 5'h04, 32'd0);
    check("live_hi", {32'd0, u_dut1.mtime_q[63:32]}, 64'd1);

    // Write landing on a tick edge: the written value wins.
    wr(1, 5'h00, 32'h55);
    rd(1, 5'h00, v);
    check("collision", {63'd0, (v == 32'h55 || v == 32'h56)}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
